// File: rtl/uart_key_decoder.sv
// rtl/uart_key_decoder.sv - 8N1 receiver that turns keyboard bytes into held paddle levels and a start pulse.
// Direction commands are held for a retriggerable window because a terminal never sends key releases.
module uart_key_decoder #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD          = 115200,
  parameter int HOLD_MS       = 60,
  parameter int START_STRETCH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down,
  output logic       start_trigger,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HOLD_CYCLES  = (CLK_FREQ / 1000) * HOLD_MS;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(START_STRETCH + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(START_STRETCH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state;
  logic          sync1, rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

  // Sampling points land mid-bit: half a bit after the falling edge, then every full bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rxs) begin
              rx_valid <= 1'b1;
              rx_byte  <= shreg;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [7:0] key;
  logic       cmd_p1_up, cmd_p1_down, cmd_p2_up, cmd_p2_down, cmd_start, cmd_release;

  always_comb begin
    key = rx_byte;
    if (rx_byte >= 8'h41 && rx_byte <= 8'h5A) key = rx_byte | 8'h20;
    cmd_p1_up   = rx_valid && (key == 8'h77);
    cmd_p1_down = rx_valid && (key == 8'h73);
    cmd_p2_up   = rx_valid && (key == 8'h69);
    cmd_p2_down = rx_valid && (key == 8'h6B);
    cmd_start   = rx_valid && (key == 8'h20 || key == 8'h0D);
    cmd_release = rx_valid && (key == 8'h78);
  end

  logic [HW-1:0] p1_cnt, p2_cnt;
  logic [SW-1:0] start_cnt;

  // Directions drop together in the cycle the window counter reaches zero.
  always_ff @(posedge clk) begin
    if (rst || cmd_release) begin
      p1_up   <= 1'b0;
      p1_down <= 1'b0;
      p1_cnt  <= '0;
      p2_up   <= 1'b0;
      p2_down <= 1'b0;
      p2_cnt  <= '0;
    end else begin
      if (cmd_p1_up || cmd_p1_down) begin
        p1_up   <= cmd_p1_up;
        p1_down <= cmd_p1_down;
        p1_cnt  <= HOLD_LOAD;
      end else if (p1_cnt != '0) begin
        p1_cnt <= p1_cnt - HW'(1);
        if (p1_cnt == HW'(1)) begin
          p1_up   <= 1'b0;
          p1_down <= 1'b0;
        end
      end
      if (cmd_p2_up || cmd_p2_down) begin
        p2_up   <= cmd_p2_up;
        p2_down <= cmd_p2_down;
        p2_cnt  <= HOLD_LOAD;
      end else if (p2_cnt != '0) begin
        p2_cnt <= p2_cnt - HW'(1);
        if (p2_cnt == HW'(1)) begin
          p2_up   <= 1'b0;
          p2_down <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_cnt <= '0;
    end else if (cmd_start) begin
      start_cnt <= STRETCH_LOAD;
    end else if (start_cnt != '0) begin
      start_cnt <= start_cnt - SW'(1);
    end
  end

  assign start_trigger = (start_cnt != '0);

endmodule

// File: tb/tb_uart_key_decoder.sv
// tb/tb_uart_key_decoder.sv - directed and random byte stimulus against a per-cycle reference model.
module tb_uart_key_decoder;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HOLD     = (CLK_FREQ / 1000) * 1;
  localparam int STRETCH  = 4;
  localparam int LAT      = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       p1_up, p1_down, p2_up, p2_down, start_trigger, rx_valid, frame_err;
  logic [7:0] rx_byte;

  uart_key_decoder #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .HOLD_MS(1), .START_STRETCH(STRETCH)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .start_trigger(start_trigger), .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int fe_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [7:0] b; int e;} exp_t;
  exp_t q[$];

  // Model: a player's direction is visible from the cycle after decode through `until`.
  int p1_dir = 0, p1_until = -1, p2_dir = 0, p2_until = -1, st_until = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_decode(input logic [7:0] b);
    logic [7:0] k;
    k = b;
    if (k >= 8'h41 && k <= 8'h5A) k = k | 8'h20;
    case (k)
      8'h77: begin p1_dir = 1; p1_until = cyc + HOLD; end
      8'h73: begin p1_dir = 2; p1_until = cyc + HOLD; end
      8'h69: begin p2_dir = 1; p2_until = cyc + HOLD; end
      8'h6B: begin p2_dir = 2; p2_until = cyc + HOLD; end
      8'h20, 8'h0D: st_until = cyc + STRETCH;
      8'h78: begin p1_dir = 0; p2_dir = 0; end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) begin
      p1_dir = 0; p2_dir = 0; p1_until = -1; p2_until = -1; st_until = -1;
      q.delete();
      chk("reset_rx_valid", rx_valid, 0);
      chk("reset_frame_err", frame_err, 0);
    end
    chk("p1_up", p1_up, (p1_dir == 1 && cyc <= p1_until));
    chk("p1_down", p1_down, (p1_dir == 2 && cyc <= p1_until));
    chk("p2_up", p2_up, (p2_dir == 1 && cyc <= p2_until));
    chk("p2_down", p2_down, (p2_dir == 2 && cyc <= p2_until));
    chk("start_trigger", start_trigger, (cyc <= st_until));
    if (frame_err) fe_seen++;
    if (rx_valid) begin
      if (q.size() == 0) begin
        chk("rx_valid_unexpected", rx_valid, 0);
      end else begin
        exp_t t;
        int d;
        t = q.pop_front();
        d = cyc - t.e;
        chk("rx_byte", rx_byte, t.b);
        checks++;
        assert (d >= LAT - 2 && d <= LAT + 2) else begin
          failures++;
          $error("FAIL rx_latency observed=%0d expected=%0d+-2", d, LAT);
        end
        model_decode(t.b);
      end
    end
    if (q.size() > 0) begin
      if (cyc > q[0].e + LAT + 2) begin
        checks++;
        failures++;
        $error("FAIL rx_timeout observed=none expected=%0h", q[0].b);
        void'(q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Must be called at a negedge; leaves the line at the stop-bit level.
  task automatic send(input logic [7:0] b, input logic stop = 1'b1);
    if (stop) begin
      exp_t t;
      t.b = b;
      t.e = cyc + 1;
      q.push_back(t);
    end
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CPB);
    end
    uart_rx = stop;
    idle(CPB);
  endtask

  logic [7:0] keys [14] = '{8'h77, 8'h57, 8'h73, 8'h53, 8'h69, 8'h49, 8'h6B,
                            8'h4B, 8'h20, 8'h0D, 8'h78, 8'h58, 8'h41, 8'h00};

  initial begin
    int fe0;
    idle(3);
    chk("reset_rx_byte", rx_byte, 8'h00);
    chk("reset_p1_up", p1_up, 0);
    chk("reset_start", start_trigger, 0);
    rst = 1'b0;
    idle(5);

    send(8'h77);
    idle(HOLD + 100);
    chk("single_up_expired", p1_up, 0);

    send(8'h57);
    idle(100);
    send(8'h77);
    idle(100);
    send(8'h53);
    idle(HOLD + 100);

    send(8'h69);
    idle(20);
    send(8'h6B);
    idle(20);
    send(8'h77);
    idle(20);
    chk("indep_p1_up", p1_up, 1);
    chk("indep_p2_down", p2_down, 1);
    send(8'h78);
    idle(20);
    chk("release_p1_up", p1_up, 0);
    chk("release_p2_down", p2_down, 0);

    send(8'h20);
    send(8'h41);
    idle(20);

    uart_rx = 1'b0;
    idle(3);
    uart_rx = 1'b1;
    idle(CPB * 12);

    fe0 = fe_seen;
    send(8'h77, 1'b0);
    idle(CPB * 20);
    uart_rx = 1'b1;
    idle(20);
    chk("frame_err_once", fe_seen - fe0, 1);
    chk("frame_err_no_up", p1_up, 0);
    send(8'h73);
    idle(5);
    chk("after_ferr_p1_down", p1_down, 1);

    uart_rx = 1'b0;
    idle(CPB);
    uart_rx = 1'b1;
    idle(CPB * 2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(CPB * 12);
    chk("midreset_p1_down", p1_down, 0);
    chk("midreset_rx_byte", rx_byte, 8'h00);
    send(8'h73);
    idle(5);
    chk("post_reset_p1_down", p1_down, 1);

    for (int n = 0; n < 25; n++) begin
      logic [7:0] b;
      int gap;
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : keys[$urandom_range(0, 13)];
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 400);
      send(b);
      idle(gap);
    end
    idle(HOLD + 100);

    chk("pending_bytes", q.size(), 0);
    chk("total_frame_err", fe_seen, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
